// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps every input vector into one gate-under-test and checks the sampled output.
// Optional build macro GATE_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               gate_sel,
  input  logic                     gut_out,
  output logic [N_IN-1:0]          vec,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic [(2**N_IN)-1:0]     tt_out
);

  localparam int unsigned NV  = 2 ** N_IN;
  localparam int unsigned CW  = N_IN + 1;
  localparam int unsigned SCW = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_APPLY   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        gsel_q, gsel_d;
  logic [SCW-1:0]    cnt_q, cnt_d;
  logic [N_IN-1:0]   vec_d;
  logic              busy_d, done_d, pass_d;
  logic [CW-1:0]     err_d;
  logic [NV-1:0]     tt_d;
  logic              expected_c;
  logic              mismatch_c;
  logic              last_c;

  // Reference value for the latched gate type at the current vector
  always_comb begin
    expected_c = 1'b0;
    case (gsel_q)
      3'd0:    expected_c = vec[0];
      3'd1:    expected_c = ~vec[0];
      3'd2:    expected_c = &vec;
      3'd3:    expected_c = |vec;
      3'd4:    expected_c = ~&vec;
      3'd5:    expected_c = ~|vec;
      3'd6:    expected_c = ^vec;
      default: expected_c = ~^vec;
    endcase
  end

  assign mismatch_c = gut_out ^ expected_c;
  assign last_c     = (vec == N_IN'(NV - 1));

  // Next-state and next-output decode
  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    cnt_d   = cnt_q;
    vec_d   = vec;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    err_d   = err_count;
    tt_d    = tt_out;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          gsel_d  = gate_sel;
          err_d   = '0;
          tt_d    = '0;
          vec_d   = '0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end

      S_APPLY: begin
        cnt_d   = SCW'(SETTLE);
        state_d = (SETTLE > 0) ? S_WAIT : S_CAPTURE;
      end

      S_WAIT: begin
        cnt_d = cnt_q - SCW'(1);
        if (cnt_q <= SCW'(1)) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        tt_d[vec] = gut_out;
        if (mismatch_c) begin
          err_d = err_count + CW'(1);
        end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
        if (mismatch_c || last_c) begin
          state_d = S_FINISH;
        end else begin
          vec_d   = vec + N_IN'(1);
          state_d = S_APPLY;
        end
`else
        if (last_c) begin
          state_d = S_FINISH;
        end else begin
          vec_d   = vec + N_IN'(1);
          state_d = S_APPLY;
        end
`endif
      end

      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count == '0);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      gsel_q    <= '0;
      cnt_q     <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      tt_out    <= '0;
    end else begin
      state_q   <= state_d;
      gsel_q    <= gsel_d;
      cnt_q     <= cnt_d;
      vec       <= vec_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_count <= err_d;
      tt_out    <= tt_d;
    end
  end

endmodule
